// File: rtl/csr_timer_array_pkg.sv
// Shared definitions for csr_timer_array: per-channel register offsets, CTRL field
// positions and the irq_id width helper.
package csr_timer_array_pkg;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_INIT = 2'd1,
    REG_VAL  = 2'd2,
    REG_CLR  = 2'd3
  } timer_reg_e;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IE_BIT       = 2;
  localparam int CTRL_CHAIN_BIT    = 3;
  localparam int CTRL_PSC_LSB      = 8;
  localparam int PSC_W             = 8;
  localparam int CSR_DATA_W        = 32;
  localparam int CSR_NUM_W         = 14;

  // A single channel still needs a 1-bit id port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic merge_bit(input logic m, input logic v, input logic o);
    return m ? v : o;
  endfunction

endpackage

// File: rtl/csr_timer_array_timer_channel.sv
// One timer channel: CTRL/INIT registers, prescaler, down-counter and pending bit.
// With TIMER_CASCADE_EN defined, channels with CHAIN_OK may tick from tick_in instead.
module csr_timer_array_timer_channel
  import csr_timer_array_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter bit CHAIN_OK  = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  freeze,
  input  logic                  wr_ctrl,
  input  logic                  wr_init,
  input  logic                  wr_clr,
  input  logic [31:0]           wmask,
  input  logic [31:0]           wvalue,
  input  logic                  tick_in,
  output logic [31:0]           ctrl_rd,
  output logic [CNT_WIDTH-1:0]  init_rd,
  output logic [CNT_WIDTH-1:0]  cnt_rd,
  output logic                  pending,
  output logic                  irq,
  output logic                  underflow_out
);

  localparam logic [CNT_WIDTH-1:0] IDLE = '1;

  logic                 en;
  logic                 periodic;
  logic                 ie;
  logic                 chain;
  logic [PSC_W-1:0]     psc;
  logic [PSC_W-1:0]     psc_cnt;
  logic [CNT_WIDTH-1:0] init;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 en_new;
  logic [PSC_W-1:0]     psc_new;
  logic [CNT_WIDTH-1:0] init_new;
  logic                 load;
  logic                 running;
  logic                 psc_hit;
  logic                 tick;
  logic                 clr;

  assign ctrl_rd = {16'b0, psc, 4'b0, chain, ie, periodic, en};
  assign init_rd = init;
  assign cnt_rd  = cnt;
  assign irq     = pending & ie;

  assign en_new   = merge_bit(wmask[CTRL_EN_BIT], wvalue[CTRL_EN_BIT], en);
  assign psc_new  = (wmask[CTRL_PSC_LSB +: PSC_W] & wvalue[CTRL_PSC_LSB +: PSC_W]) |
                    (~wmask[CTRL_PSC_LSB +: PSC_W] & psc);
  assign init_new = (wmask[CNT_WIDTH-1:0] & wvalue[CNT_WIDTH-1:0]) |
                    (~wmask[CNT_WIDTH-1:0] & init);

  // An all-ones count marks a finished one-shot channel that waits for a reload.
  assign running = en && (cnt != IDLE);
  assign psc_hit = (psc_cnt == psc);
  assign load    = wr_ctrl & en_new;
  assign tick    = chain ? (running & tick_in) : (running & ~freeze & psc_hit);
  assign clr     = wr_clr & wmask[0] & wvalue[0];

  assign underflow_out = tick & ~load & (cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      ie       <= 1'b0;
      psc      <= '0;
      init     <= '0;
    end else begin
      if (wr_ctrl) begin
        en       <= en_new;
        periodic <= merge_bit(wmask[CTRL_PERIODIC_BIT], wvalue[CTRL_PERIODIC_BIT], periodic);
        ie       <= merge_bit(wmask[CTRL_IE_BIT], wvalue[CTRL_IE_BIT], ie);
        psc      <= psc_new;
      end
      if (wr_init) begin
        init <= init_new;
      end
    end
  end

`ifdef TIMER_CASCADE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain <= 1'b0;
    end else if (wr_ctrl && CHAIN_OK) begin
      chain <= merge_bit(wmask[CTRL_CHAIN_BIT], wvalue[CTRL_CHAIN_BIT], chain);
    end
  end
`else
  logic unused_cascade;
  assign chain          = 1'b0;
  assign unused_cascade = tick_in | CHAIN_OK;
`endif

  // A load restarts the channel and wins over a tick landing on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= IDLE;
      psc_cnt <= '0;
    end else if (load) begin
      cnt     <= init;
      psc_cnt <= '0;
    end else begin
      if (running && !freeze && !chain) begin
        psc_cnt <= psc_hit ? '0 : psc_cnt + 8'd1;
      end
      if (tick) begin
        if (cnt != '0) begin
          cnt <= cnt - CNT_WIDTH'(1);
        end else begin
          cnt <= periodic ? init : IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
    end else if (underflow_out) begin
      pending <= 1'b1;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/csr_timer_array.sv
// Multi-channel CSR timer block: address decode, read mux, channel array and
// fixed-priority interrupt encoder. Optional channel chaining under TIMER_CASCADE_EN.
module csr_timer_array
  import csr_timer_array_pkg::*;
#(
  parameter int          NUM_TIMERS = 2,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [13:0] CSR_BASE   = 14'h60,
  localparam int         ID_W       = id_width(NUM_TIMERS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  csr_re,
  input  logic [13:0]           csr_num,
  output logic [31:0]           csr_rvalue,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  input  logic                  freeze,
  output logic [NUM_TIMERS-1:0] timer_irq,
  output logic                  irq_any,
  output logic [ID_W-1:0]       irq_id
);

  logic [13:0]           off;
  logic                  in_range;
  timer_reg_e            reg_sel;
  logic [NUM_TIMERS-1:0] ch_sel;
  logic [NUM_TIMERS-1:0] wr_ctrl;
  logic [NUM_TIMERS-1:0] wr_init;
  logic [NUM_TIMERS-1:0] wr_clr;
  logic [NUM_TIMERS-1:0] pending;
  logic [NUM_TIMERS:0]   uf_chain;
  logic [31:0]           ctrl_rd [NUM_TIMERS];
  logic [CNT_WIDTH-1:0]  init_rd [NUM_TIMERS];
  logic [CNT_WIDTH-1:0]  cnt_rd  [NUM_TIMERS];
  logic                  unused_inputs;

  // Numbers below the base wrap to large offsets, so one compare covers both ends.
  assign off      = csr_num - CSR_BASE;
  assign in_range = (off < 14'(4 * NUM_TIMERS));
  assign reg_sel  = timer_reg_e'(off[1:0]);

  assign uf_chain[0]   = 1'b0;
  assign unused_inputs = ^{csr_re, uf_chain[NUM_TIMERS]};

  generate
    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
      assign ch_sel[i]  = in_range && (off[13:2] == 12'(i));
      assign wr_ctrl[i] = csr_we & ch_sel[i] & (reg_sel == REG_CTRL);
      assign wr_init[i] = csr_we & ch_sel[i] & (reg_sel == REG_INIT);
      assign wr_clr[i]  = csr_we & ch_sel[i] & (reg_sel == REG_CLR);

      csr_timer_array_timer_channel #(
        .CNT_WIDTH (CNT_WIDTH),
        .CHAIN_OK  (i > 0)
      ) u_ch (
        .clk           (clk),
        .resetn        (resetn),
        .freeze        (freeze),
        .wr_ctrl       (wr_ctrl[i]),
        .wr_init       (wr_init[i]),
        .wr_clr        (wr_clr[i]),
        .wmask         (csr_wmask),
        .wvalue        (csr_wvalue),
        .tick_in       (uf_chain[i]),
        .ctrl_rd       (ctrl_rd[i]),
        .init_rd       (init_rd[i]),
        .cnt_rd        (cnt_rd[i]),
        .pending       (pending[i]),
        .irq           (timer_irq[i]),
        .underflow_out (uf_chain[i+1])
      );
    end
  endgenerate

  always_comb begin
    csr_rvalue = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (ch_sel[i]) begin
        case (reg_sel)
          REG_CTRL: csr_rvalue = ctrl_rd[i];
          REG_INIT: csr_rvalue = 32'(init_rd[i]);
          REG_VAL:  csr_rvalue = 32'(cnt_rd[i]);
          REG_CLR:  csr_rvalue = {31'b0, pending[i]};
          default:  csr_rvalue = '0;
        endcase
      end
    end
  end

  assign irq_any = |timer_irq;

  // Scanning downwards lets the lowest set index win.
  always_comb begin
    irq_id = '0;
    for (int i = NUM_TIMERS - 1; i >= 0; i--) begin
      if (timer_irq[i]) begin
        irq_id = ID_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_csr_timer_array.sv
// Bench for csr_timer_array: directed steps followed by random CSR traffic against a
// cycle-level behavioural model. Define TIMER_CASCADE_EN to cover channel chaining.
module tb_csr_timer_array;

  localparam int          N    = 2;
  localparam int          CW   = 32;
  localparam logic [13:0] BASE = 14'h60;
  localparam int          ID_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic            clk;
  logic            resetn;
  logic            csr_re;
  logic [13:0]     csr_num;
  logic [31:0]     csr_rvalue;
  logic            csr_we;
  logic [31:0]     csr_wmask;
  logic [31:0]     csr_wvalue;
  logic            freeze;
  logic [N-1:0]    timer_irq;
  logic            irq_any;
  logic [ID_W-1:0] irq_id;

  int errors = 0;
  int checks = 0;
  int cycleNo = 0;

  logic [31:0]     lastRead;
  logic [N-1:0]    lastIrq;
  logic [ID_W-1:0] lastId;

  logic [31:0] mCtrl [N];
  logic [31:0] mInit [N];
  logic [31:0] mCnt  [N];
  logic [7:0]  mPsc  [N];
  logic        mPend [N];

  csr_timer_array #(
    .NUM_TIMERS (N),
    .CNT_WIDTH  (CW),
    .CSR_BASE   (BASE)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .csr_re     (csr_re),
    .csr_num    (csr_num),
    .csr_rvalue (csr_rvalue),
    .csr_we     (csr_we),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .freeze     (freeze),
    .timer_irq  (timer_irq),
    .irq_any    (irq_any),
    .irq_id     (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s @cycle %0d: observed=0x%08h expected=0x%08h", tag, cycleNo, obs, exp);
    end
  endtask

  function automatic logic [13:0] addr(input int ch, input int r);
    return BASE + 14'(4 * ch + r);
  endfunction

  function automatic logic [31:0] ctrlMask(input int ch);
`ifdef TIMER_CASCADE_EN
    return (ch > 0) ? 32'h0000_FF0F : 32'h0000_FF07;
`else
    return 32'h0000_FF07 | 32'(ch & 0);
`endif
  endfunction

  function automatic logic [31:0] regWord(input int ch, input int r);
    case (r)
      0:       return mCtrl[ch];
      1:       return mInit[ch];
      2:       return mCnt[ch];
      default: return {31'b0, mPend[ch]};
    endcase
  endfunction

  function automatic logic [31:0] modelRead(input logic [13:0] num);
    int off;
    off = int'(num) - int'(BASE);
    if (off >= 0 && off < 4 * N) return regWord(off / 4, off % 4);
    return 32'h0;
  endfunction

  function automatic logic [N-1:0] modelIrq();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mPend[i] & mCtrl[i][2];
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mCtrl[i] = 32'h0;
      mInit[i] = 32'h0;
      mCnt[i]  = ONES;
      mPsc[i]  = 8'h0;
      mPend[i] = 1'b0;
    end
  endtask

  // One clock of the timer rules, applied to every channel from the pre-edge state.
  task automatic modelStep(input logic we, input logic [13:0] num, input logic [31:0] mask,
                           input logic [31:0] value, input logic frz);
    logic [31:0] nCtrl [N];
    logic [31:0] nInit [N];
    logic [31:0] nCnt  [N];
    logic [7:0]  nPsc  [N];
    logic        nPend [N];
    logic        prevUf;
    logic        hit;
    logic        tick;
    logic        load;
    logic        uf;
    logic        chained;
    logic [31:0] merged;
    int          off;
    prevUf = 1'b0;
    for (int i = 0; i < N; i++) begin
      nCtrl[i] = mCtrl[i];
      nInit[i] = mInit[i];
      nCnt[i]  = mCnt[i];
      nPsc[i]  = mPsc[i];
      nPend[i] = mPend[i];
      off      = int'(num) - int'(BASE) - 4 * i;
      hit      = we && off >= 0 && off < 4;
      merged   = hit ? ((mask & value) | (~mask & regWord(i, off))) : 32'h0;
      chained  = mCtrl[i][3];
      tick     = 1'b0;
      if (chained) begin
        tick = mCtrl[i][0] && mCnt[i] != ONES && prevUf;
      end else if (mCtrl[i][0] && !frz && mCnt[i] != ONES) begin
        if (mPsc[i] == mCtrl[i][15:8]) begin
          tick    = 1'b1;
          nPsc[i] = 8'h0;
        end else begin
          nPsc[i] = mPsc[i] + 8'h1;
        end
      end
      load = hit && off == 0 && merged[0];
      if (hit && off == 0) nCtrl[i] = merged & ctrlMask(i);
      if (hit && off == 1) nInit[i] = merged;
      uf = 1'b0;
      if (load) begin
        nCnt[i] = mInit[i];
        nPsc[i] = 8'h0;
      end else if (tick) begin
        if (mCnt[i] != 32'h0) begin
          nCnt[i] = mCnt[i] - 32'h1;
        end else begin
          uf       = 1'b1;
          nPend[i] = 1'b1;
          nCnt[i]  = mCtrl[i][1] ? mInit[i] : ONES;
        end
      end
      if (hit && off == 3 && mask[0] && value[0] && !uf) nPend[i] = 1'b0;
      prevUf = uf;
    end
    for (int i = 0; i < N; i++) begin
      mCtrl[i] = nCtrl[i];
      mInit[i] = nInit[i];
      mCnt[i]  = nCnt[i];
      mPsc[i]  = nPsc[i];
      mPend[i] = nPend[i];
    end
  endtask

  task automatic checkOutput(input logic [13:0] num);
    logic [N-1:0] expIrq;
    int           expId;
    expIrq = modelIrq();
    expId  = 0;
    for (int i = N - 1; i >= 0; i--) if (expIrq[i]) expId = i;
    check("csr_rvalue", csr_rvalue, modelRead(num));
    check("timer_irq", 32'(timer_irq), 32'(expIrq));
    check("irq_any", 32'(irq_any), 32'(|expIrq));
    check("irq_id", 32'(irq_id), 32'(expId));
  endtask

  task automatic applyStimulus(input logic we, input logic [13:0] num, input logic [31:0] mask,
                               input logic [31:0] value, input logic frz);
    csr_we     = we;
    csr_num    = num;
    csr_wmask  = mask;
    csr_wvalue = value;
    freeze     = frz;
    @(negedge clk);
    lastRead = csr_rvalue;
    lastIrq  = timer_irq;
    lastId   = irq_id;
    checkOutput(num);
    modelStep(we, num, mask, value, frz);
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  task automatic writeReg(input int ch, input int r, input logic [31:0] value);
    applyStimulus(1'b1, addr(ch, r), ONES, value, 1'b0);
  endtask

  task automatic readReg(input int ch, input int r);
    applyStimulus(1'b0, addr(ch, r), 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] clrExp [10];
    int          rch;
    int          rr;
    logic        rwe;
    logic        rfrz;
    logic [13:0] ra;
    logic [31:0] rmask;
    logic [31:0] rval;

    resetn     = 1'b0;
    csr_re     = 1'b1;
    csr_we     = 1'b0;
    csr_num    = BASE;
    csr_wmask  = 32'h0;
    csr_wvalue = 32'h0;
    freeze     = 1'b0;
    modelReset();
    #12 resetn = 1'b1;
    @(posedge clk);
    #1;

    readReg(0, 2);
    check("reset_val0", lastRead, ONES);
    readReg(0, 0);
    check("reset_ctrl0", lastRead, 32'h0);
    check("reset_irq", 32'(lastIrq), 32'h0);

    // One-shot, PSC=0: VAL walks 3..0 then parks at all-ones with pending set.
    writeReg(0, 1, 32'd3);
    writeReg(0, 0, 32'h5);
    for (int k = 0; k < 4; k++) begin
      readReg(0, 2);
      check("oneshot_val", lastRead, 32'(3 - k));
    end
    readReg(0, 2);
    check("oneshot_idle", lastRead, ONES);
    check("oneshot_irq0", 32'(lastIrq[0]), 32'h1);
    check("oneshot_id", 32'(lastId), 32'h0);
    readReg(0, 2);
    check("oneshot_stays", lastRead, ONES);
    writeReg(0, 3, 32'h1);
    readReg(0, 3);
    check("oneshot_clr", lastRead, 32'h0);

    // Periodic INIT=1 PSC=1: pending every 4 cycles; CLR loses to a same-cycle set.
    clrExp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0};
    writeReg(0, 1, 32'd1);
    writeReg(0, 0, 32'h107);
    for (int k = 0; k < 10; k++) begin
      applyStimulus((k == 5 || k == 7 || k == 8), addr(0, 3), ONES, 32'h1, 1'b0);
      check("periodic_pending", lastRead, clrExp[k]);
    end
    writeReg(0, 0, 32'h0);
    writeReg(0, 3, 32'h1);

    // Both channels pending with IE, then clear ch0, then ch0 pending without IE.
    writeReg(0, 1, 32'd0);
    writeReg(1, 1, 32'd0);
    writeReg(0, 0, 32'h5);
    writeReg(1, 0, 32'h5);
    readReg(1, 3);
    readReg(1, 3);
    check("prio_both_irq", 32'(lastIrq), 32'h3);
    check("prio_both_id", 32'(lastId), 32'h0);
    writeReg(0, 3, 32'h1);
    readReg(0, 3);
    check("prio_ch1_id", 32'(lastId), 32'h1);
    writeReg(0, 0, 32'h1);
    readReg(0, 3);
    readReg(0, 3);
    check("ie0_pending", lastRead, 32'h1);
    check("ie0_masked_irq", 32'(lastIrq), 32'h2);
    writeReg(0, 3, 32'h1);
    writeReg(1, 3, 32'h1);

    // Freeze mid-count, masked INIT write, unmapped CSR numbers.
    writeReg(0, 1, 32'd100);
    writeReg(0, 0, 32'h5);
    for (int k = 0; k < 5; k++) readReg(0, 2);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, addr(0, 2), 32'h0, 32'h0, 1'b1);
      check("freeze_val", lastRead, 32'd95);
    end
    readReg(0, 2);
    check("unfreeze_val", lastRead, 32'd95);
    readReg(0, 2);
    check("resume_val", lastRead, 32'd94);
    applyStimulus(1'b1, addr(0, 1), 32'h0, 32'h0000_DEAD, 1'b0);
    readReg(0, 1);
    check("init_masked", lastRead, 32'd100);
    writeReg(N, 0, ONES);
    readReg(N, 0);
    check("unmapped_hi", lastRead, 32'h0);
    applyStimulus(1'b0, BASE - 14'd1, 32'h0, 32'h0, 1'b0);
    check("unmapped_lo", lastRead, 32'h0);
    writeReg(0, 0, 32'h0);

`ifdef TIMER_CASCADE_EN
    // ch1 chained to periodic ch0 (INIT=1): ch1 INIT=2 pends after 6 ch0 ticks.
    writeReg(1, 1, 32'd2);
    writeReg(1, 0, 32'hD);
    readReg(1, 0);
    check("chain_ctrl", lastRead, 32'hD);
    writeReg(0, 1, 32'd1);
    writeReg(0, 0, 32'h3);
    for (int k = 0; k < 7; k++) begin
      readReg(1, 3);
      check("chain_pending", lastRead, (k == 6) ? 32'h1 : 32'h0);
    end
    writeReg(0, 0, 32'h0);
    writeReg(1, 0, 32'h0);
    writeReg(1, 3, 32'h1);
`else
    writeReg(1, 0, 32'h8);
    readReg(1, 0);
    check("chain_bit_absent", lastRead, 32'h0);
`endif

    // Asynchronous reset with cnt=5 takes effect without waiting for a clock edge.
    writeReg(0, 1, 32'd8);
    writeReg(0, 0, 32'h1);
    for (int k = 0; k < 3; k++) readReg(0, 2);
    csr_num = addr(0, 2);
    #1;
    check("prereset_val", csr_rvalue, 32'd5);
    resetn = 1'b0;
    #1;
    check("async_reset_val", csr_rvalue, ONES);
    check("async_reset_any", 32'(irq_any), 32'h0);
    csr_num = addr(0, 0);
    #1;
    check("async_reset_ctrl", csr_rvalue, 32'h0);
    modelReset();
    resetn = 1'b1;
    readReg(0, 2);
    check("post_reset_val", lastRead, ONES);
    readReg(0, 2);
    check("post_reset_hold", lastRead, ONES);

    // Random CSR traffic with small INIT/PSC values so events occur often.
    for (int n = 0; n < 400; n++) begin
      rch  = int'($urandom_range(0, N - 1));
      rr   = int'($urandom_range(0, 3));
      rwe  = ($urandom_range(0, 2) == 0);
      rfrz = ($urandom_range(0, 9) == 0);
      ra   = ($urandom_range(0, 15) == 0) ? BASE + 14'(4 * N + int'($urandom_range(0, 3)))
                                          : addr(rch, rr);
      rmask = ($urandom_range(0, 1) == 1) ? ONES : $urandom;
      case (rr)
        0:       rval = {16'h0, 8'($urandom_range(0, 2)), 4'h0, 4'($urandom)};
        1:       rval = 32'($urandom_range(0, 6));
        default: rval = $urandom;
      endcase
      applyStimulus(rwe, ra, rmask, rval, rfrz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
